// File: rtl/vme_cycle_initiator_pkg.sv
// FSM encoding and completion codes shared by the VME cycle initiator files.
package vme_cycle_initiator_pkg;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'b0000001,
    ST_SETUP    = 7'b0000010,
    ST_ASDLY    = 7'b0000100,
    ST_WAIT_ACK = 7'b0001000,
    ST_RELEASE  = 7'b0010000,
    ST_WAIT_REL = 7'b0100000,
    ST_DONE     = 7'b1000000
  } state_t;

  localparam logic [1:0] STAT_OK   = 2'b00;
  localparam logic [1:0] STAT_BERR = 2'b01;
  localparam logic [1:0] STAT_TMO  = 2'b10;

endpackage

// File: rtl/vme_init_sync.sv
// Two-flop synchronizer for asynchronous active-low bus replies; resets to all ones (idle).
module vme_init_sync #(
  parameter int W = 1
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vme_cycle_initiator.sv
// VME A24/D16 master: runs one AS/DS strobe cycle per accepted request and reports DTACK/BERR/timeout.
// Every bus output is registered; replies are acted on one clock after the 2-flop synchronizer.
module vme_cycle_initiator
  import vme_cycle_initiator_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int DS_DLY_CYC  = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        req_wr_i,
  input  logic [22:0] req_adr_i,
  input  logic [5:0]  req_am_i,
  input  logic [15:0] req_wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  status_o,
  output logic [15:0] rdata_o,
  output logic [22:0] vme_a_o,
  output logic [5:0]  vme_am_o,
  output logic        _as_o,
  output logic        _ds0_o,
  output logic        _ds1_o,
  output logic        _write_o,
  output logic [15:0] vme_d_out_o,
  output logic        vme_d_oe_o,
  input  logic [15:0] vme_d_in_i,
  input  logic        _dtack_i,
  input  logic        _berr_i
);

  localparam int CMAX = (SETUP_CYC > DS_DLY_CYC) ? SETUP_CYC : DS_DLY_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] rdata_q, rdata_d;
  logic [22:0] a_q, a_d;
  logic [5:0]  am_q, am_d;
  logic        as_n_q, as_n_d;
  logic        ds_n_q, ds_n_d;
  logic        write_n_q, write_n_d;
  logic [15:0] dout_q, dout_d;
  logic        doe_q, doe_d;

  logic [1:0]  reply_s;
  logic        dtack_s, berr_s;

  vme_init_sync #(.W(2)) u_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     ({_berr_i, _dtack_i}),
    .q_o     (reply_s)
  );

  assign dtack_s = reply_s[0];
  assign berr_s  = reply_s[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    status_d  = status_q;
    rdata_d   = rdata_q;
    a_d       = a_q;
    am_d      = am_q;
    as_n_d    = as_n_q;
    ds_n_d    = ds_n_q;
    write_n_d = write_n_q;
    dout_d    = dout_q;
    doe_d     = doe_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          busy_d    = 1'b1;
          status_d  = STAT_OK;
          a_d       = req_adr_i;
          am_d      = req_am_i;
          write_n_d = ~req_wr_i;
          doe_d     = req_wr_i;
          if (req_wr_i) dout_d = req_wdata_i;
          cnt_d     = CW'(SETUP_CYC - 1);
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          as_n_d  = 1'b0;
          cnt_d   = CW'(DS_DLY_CYC - 1);
          state_d = ST_ASDLY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ASDLY: begin
        if (cnt_q == '0) begin
          ds_n_d  = 1'b0;
          timer_d = '0;
          state_d = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // A reply seen on the same clock as the timeout still counts as a reply.
        if (!berr_s || !dtack_s || timer_q == TW'(TIMEOUT_CYC - 1)) begin
          as_n_d  = 1'b1;
          ds_n_d  = 1'b1;
          doe_d   = 1'b0;
          state_d = ST_RELEASE;
          if (!berr_s) begin
            status_d = STAT_BERR;
          end else if (!dtack_s) begin
            status_d = STAT_OK;
            if (write_n_q) rdata_d = vme_d_in_i;
          end else begin
            status_d = STAT_TMO;
          end
        end else if (timer_q != TW'(TIMEOUT_CYC)) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (status_q == STAT_TMO || (dtack_s && berr_s)) begin
          done_d    = 1'b1;
          busy_d    = 1'b0;
          write_n_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= STAT_OK;
      rdata_q   <= '0;
      a_q       <= '0;
      am_q      <= '0;
      as_n_q    <= 1'b1;
      ds_n_q    <= 1'b1;
      write_n_q <= 1'b1;
      dout_q    <= '0;
      doe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
      a_q       <= a_d;
      am_q      <= am_d;
      as_n_q    <= as_n_d;
      ds_n_q    <= ds_n_d;
      write_n_q <= write_n_d;
      dout_q    <= dout_d;
      doe_q     <= doe_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign rdata_o     = rdata_q;
  assign vme_a_o     = a_q;
  assign vme_am_o    = am_q;
  assign _as_o       = as_n_q;
  assign _ds0_o      = ds_n_q;
  assign _ds1_o      = ds_n_q;
  assign _write_o    = write_n_q;
  assign vme_d_out_o = dout_q;
  assign vme_d_oe_o  = doe_q;

endmodule

// File: tb/tb_vme_cycle_initiator.sv
// Bench for vme_cycle_initiator: table of bus cycles, hand-written corner sequences, then randomized cycles.
module tb_vme_cycle_initiator;

  localparam int SETUP = 2;
  localparam int DSD   = 1;
  localparam int TMO   = 16;

  localparam int R_DTACK = 0;
  localparam int R_BERR  = 1;
  localparam int R_NONE  = 2;
  localparam int R_BOTH  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_wr = 1'b0;
  logic [22:0] req_adr = '0;
  logic [5:0]  req_am = '0;
  logic [15:0] req_wdata = '0;
  logic        busy, done;
  logic [1:0]  status;
  logic [15:0] rdata;
  logic [22:0] vme_a;
  logic [5:0]  vme_am;
  logic        as_n, ds0_n, ds1_n, write_n;
  logic [15:0] vme_d_out;
  logic        vme_d_oe;
  logic [15:0] vme_d_in = '0;
  logic        dtack_n = 1'b1;
  logic        berr_n = 1'b1;

  vme_cycle_initiator #(
    .SETUP_CYC   (SETUP),
    .DS_DLY_CYC  (DSD),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clock_i     (clk),
    .reset_i     (reset),
    .req_i       (req),
    .req_wr_i    (req_wr),
    .req_adr_i   (req_adr),
    .req_am_i    (req_am),
    .req_wdata_i (req_wdata),
    .busy_o      (busy),
    .done_o      (done),
    .status_o    (status),
    .rdata_o     (rdata),
    .vme_a_o     (vme_a),
    .vme_am_o    (vme_am),
    ._as_o       (as_n),
    ._ds0_o      (ds0_n),
    ._ds1_o      (ds1_n),
    ._write_o    (write_n),
    .vme_d_out_o (vme_d_out),
    .vme_d_oe_o  (vme_d_oe),
    .vme_d_in_i  (vme_d_in),
    ._dtack_i    (dtack_n),
    ._berr_i     (berr_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [22:0] adr;
    logic [5:0]  am;
    logic [15:0] wdata;
    int          resp;
    int          dly;
    int          hold;
    int          hold_b;
    logic [15:0] bus;
    logic [1:0]  exp_status;
    logic [15:0] exp_rdata;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Observations of the most recent cycle, in clocks after the accepting edge.
  int          t_as, t_ds, t_rel, t_done;
  logic        oe_at_ds, ds1_at_ds, wr_n_at_ds, oe_at_rel, oe_any;
  logic [15:0] d_at_ds;
  logic [22:0] a_at_ds;
  logic [5:0]  am_at_ds;
  logic [1:0]  st_at_done;
  logic [15:0] rd_at_done;
  logic        busy_at_done, done_after, write_after;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one request and plays the slave: reply dly clocks after DS low, hold lines until strobes release.
  task automatic do_cycle(input vec_t v);
    bit on;
    on = 1'b0;
    req_wr = v.wr; req_adr = v.adr; req_am = v.am; req_wdata = v.wdata; req = 1'b1;
    t_as = -1; t_ds = -1; t_rel = -1; t_done = -1; oe_any = 1'b0;
    step();
    req = 1'b0;
    for (int t = 0; t < 300 && t_done < 0; t++) begin
      if (t > 0) step();
      oe_any = oe_any | vme_d_oe;
      if (as_n == 1'b0 && t_as < 0) t_as = t;
      if (ds0_n == 1'b0 && t_ds < 0) begin
        t_ds = t; oe_at_ds = vme_d_oe; ds1_at_ds = ds1_n; wr_n_at_ds = write_n;
        d_at_ds = vme_d_out; a_at_ds = vme_a; am_at_ds = vme_am;
      end
      if (t_ds >= 0 && t_rel < 0 && ds0_n && ds1_n && as_n) begin
        t_rel = t; oe_at_rel = vme_d_oe;
      end
      if (t_ds >= 0 && v.resp != R_NONE && !on && t >= t_ds + v.dly) begin
        on = 1'b1;
        vme_d_in = v.bus;
        if (v.resp == R_DTACK || v.resp == R_BOTH) dtack_n = 1'b0;
        if (v.resp == R_BERR  || v.resp == R_BOTH) berr_n = 1'b0;
      end
      if (on && t_rel >= 0) begin
        if (t >= t_rel + v.hold)   dtack_n = 1'b1;
        if (t >= t_rel + v.hold_b) berr_n = 1'b1;
      end
      if (done) begin
        t_done = t; st_at_done = status; rd_at_done = rdata; busy_at_done = busy;
      end
    end
    dtack_n = 1'b1;
    berr_n = 1'b1;
    step();
    done_after = done;
    write_after = write_n;
  endtask

  task automatic check_cycle(input vec_t v, input logic [1:0] exp_st, input logic [15:0] exp_rd);
    int exp_rel, exp_done, hd;
    hd = 0;
    if ((v.resp == R_DTACK || v.resp == R_BOTH) && v.hold > hd) hd = v.hold;
    if ((v.resp == R_BERR  || v.resp == R_BOTH) && v.hold_b > hd) hd = v.hold_b;
    // Reply is acted on 2 sync clocks + 1 after it is driven; lines released hd clocks after strobes.
    exp_rel  = (v.resp == R_NONE) ? t_ds + TMO : t_ds + v.dly + 3;
    exp_done = (v.resp == R_NONE) ? exp_rel + 2 : exp_rel + hd + 3;
    chk("as_after_req", 32'(t_as), 32'(SETUP));
    chk("ds_after_as", 32'(t_ds - t_as), 32'(DSD));
    chk("ds1_with_ds0", 32'(ds1_at_ds), 32'(0));
    chk("vme_a", 32'(a_at_ds), 32'(v.adr));
    chk("vme_am", 32'(am_at_ds), 32'(v.am));
    chk("write_n", 32'(wr_n_at_ds), 32'(!v.wr));
    chk("d_oe_at_ds", 32'(oe_at_ds), 32'(v.wr));
    if (v.wr) chk("d_out", 32'(d_at_ds), 32'(v.wdata));
    else      chk("d_oe_read_never", 32'(oe_any), 32'(0));
    chk("strobe_release", 32'(t_rel), 32'(exp_rel));
    chk("d_oe_at_release", 32'(oe_at_rel), 32'(0));
    chk("done_time", 32'(t_done), 32'(exp_done));
    chk("status", 32'(st_at_done), 32'(exp_st));
    chk("busy_at_done", 32'(busy_at_done), 32'(0));
    chk("rdata", 32'(rd_at_done), 32'(exp_rd));
    chk("done_one_clock", 32'(done_after), 32'(0));
    chk("write_n_idle", 32'(write_after), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    bit got;
    logic [15:0] rd_model;
    logic [1:0]  st_model;

    tbl[0] = '{1'b1, 23'h070000, 6'h39, 16'h1234, R_DTACK, 5, 0, 0, 16'h0000, 2'b00, 16'h0000};
    tbl[1] = '{1'b0, 23'h000004, 6'h39, 16'h0000, R_DTACK, 2, 1, 0, 16'hBEEF, 2'b00, 16'hBEEF};
    tbl[2] = '{1'b0, 23'h000008, 6'h39, 16'h0000, R_NONE,  0, 0, 0, 16'h7777, 2'b10, 16'hBEEF};
    tbl[3] = '{1'b1, 23'h000020, 6'h39, 16'hABCD, R_BOTH,  1, 0, 4, 16'h0000, 2'b01, 16'hBEEF};
    tbl[4] = '{1'b0, 23'h00000C, 6'h3D, 16'h0000, R_BERR,  0, 0, 2, 16'h1111, 2'b01, 16'hBEEF};
    tbl[5] = '{1'b0, 23'h000006, 6'h39, 16'h0000, R_DTACK, 0, 3, 0, 16'hCAFE, 2'b00, 16'hCAFE};

    // Reset held for three clocks.
    reset = 1'b1;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_status", 32'(status), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_vme_a", 32'(vme_a), 32'(0));
    chk("rst_vme_am", 32'(vme_am), 32'(0));
    chk("rst_strobes", 32'({as_n, ds0_n, ds1_n, write_n}), 32'(4'hF));
    chk("rst_d_out", 32'(vme_d_out), 32'(0));
    chk("rst_d_oe", 32'(vme_d_oe), 32'(0));
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      do_cycle(tbl[i]);
      check_cycle(tbl[i], tbl[i].exp_status, tbl[i].exp_rdata);
    end
    rd_model = 16'hCAFE;

    // req presented on the DONE->IDLE clock is only taken one clock later.
    req_wr = 1'b1; req_adr = 23'h000040; req_am = 6'h39; req_wdata = 16'h5555; req = 1'b1;
    step();
    req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (done) got = 1'b1;
    end
    chk("seqA_done_seen", 32'(got), 32'(1));
    req_adr = 23'h000100; req_wdata = 16'h0F0F; req = 1'b1;
    step();
    chk("req_in_done_ignored", 32'(busy), 32'(0));
    chk("adr_held_after_done", 32'(vme_a), 32'(23'h000040));
    step();
    req = 1'b0;
    chk("req_after_done_taken", 32'(busy), 32'(1));
    chk("adr_captured", 32'(vme_a), 32'(23'h000100));
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (done) got = 1'b1;
    end
    chk("seqB_done_seen", 32'(got), 32'(1));
    chk("seqB_status_tmo", 32'(status), 32'(2'b10));
    step();

    // Second req during WAIT_ACK is dropped, then a mid-cycle reset aborts the cycle.
    req_wr = 1'b0; req_adr = 23'h012345; req_am = 6'h3D; req = 1'b1;
    step();
    req = 1'b0;
    repeat (6) step();
    chk("mid_ds_low", 32'(ds0_n), 32'(0));
    req_wr = 1'b1; req_adr = 23'h07ABCD; req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("mid_busy_kept", 32'(busy), 32'(1));
    chk("mid_adr_kept", 32'(vme_a), 32'(23'h012345));
    chk("mid_write_n_kept", 32'(write_n), 32'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_strobes_high", 32'({as_n, ds0_n, ds1_n}), 32'(3'b111));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_status", 32'(status), 32'(0));
    chk("abort_d_oe", 32'(vme_d_oe), 32'(0));
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) got = 1'b1;
    end
    chk("abort_no_done", 32'(got), 32'(0));
    v = '{1'b0, 23'h000010, 6'h39, 16'h0000, R_DTACK, 1, 0, 0, 16'h5A5A, 2'b00, 16'h5A5A};
    do_cycle(v);
    check_cycle(v, v.exp_status, v.exp_rdata);
    rd_model = 16'h5A5A;

    // Randomized cycles against a reference that only knows reply kind and read/write.
    for (int i = 0; i < 40; i++) begin
      v.resp   = int'($urandom_range(0, 3));
      v.wr     = (v.resp == R_BOTH) ? 1'b1 : 1'($urandom);
      v.adr    = 23'($urandom);
      v.am     = 6'($urandom);
      v.wdata  = 16'($urandom);
      v.bus    = 16'($urandom);
      v.dly    = int'($urandom_range(0, 10));
      v.hold   = int'($urandom_range(0, 3));
      v.hold_b = int'($urandom_range(0, 3));
      case (v.resp)
        R_DTACK: st_model = 2'b00;
        R_NONE:  st_model = 2'b10;
        default: st_model = 2'b01;
      endcase
      if (!v.wr && v.resp == R_DTACK) rd_model = v.bus;
      do_cycle(v);
      check_cycle(v, st_model, rd_model);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
